// File: rtl/sn74xx194.sv
// rtl/sn74xx194.sv - 4-bit bidirectional universal shift register with parallel load (74194 style)
//
// Purpose:
//   Parameterised universal shift register. The register contents are the
//   only state; every change happens on the rising clock edge except reset,
//   which clears the register asynchronously.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset, clears out
//   mode  in   2      {S1,S0}: 00 hold, 01 shift right, 10 shift left, 11 load
//   sr    in   1      serial input for shift right, enters at bit 0 (QA)
//   sl    in   1      serial input for shift left, enters at bit WIDTH-1 (QD)
//   d     in   WIDTH  parallel load data, bit 0 is A
//   out   out  WIDTH  register contents, bit 0 is QA
//
// Cascading needs no glue: for shift right, feed out[WIDTH-1] of one stage
// into sr of the next; for shift left, feed out[0] into sl of the previous.

module sn74xx194 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      case (mode)
        2'b00:   out <= out;
        // Shift toward the MSB; the bit leaving out[WIDTH-1] is lost.
        2'b01:   out <= {out[WIDTH-2:0], sr};
        // Shift toward the LSB; the bit leaving out[0] is lost.
        2'b10:   out <= {sl, out[WIDTH-1:1]};
        2'b11:   out <= d;
        // An unknown mode poisons the register instead of silently holding,
        // so a floating select is visible in simulation.
        default: out <= 'x;
      endcase
    end
  end

endmodule

// File: tb/tb_sn74xx194.sv
// tb/tb_sn74xx194.sv - scoreboard testbench for sn74xx194
module tb_sn74xx194;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       sr = 1'b0;
  logic       sl = 1'b0;
  logic [3:0] d = 4'b0000;
  logic [3:0] out;

  // Second stage for the shift-right cascade; its sr is the low stage's MSB.
  logic [1:0] hi_mode = 2'b00;
  logic [3:0] hi_d = 4'b0000;
  logic [3:0] hi_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] exp;
    bit         hi;
  } entry_t;

  entry_t sb[$];
  event   chk_ev;

  sn74xx194 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sr   (sr),
    .sl   (sl),
    .d    (d),
    .out  (out)
  );

  sn74xx194 #(.WIDTH(4)) hi_stage (
    .clk  (clk),
    .rst  (rst),
    .mode (hi_mode),
    .sr   (out[3]),
    .sl   (1'b0),
    .d    (hi_d),
    .out  (hi_out)
  );

  always #5 clk = ~clk;

  // Quad 2-to-1 selector with inverting outputs feeding d; strobe high forces ones.
  function automatic logic [3:0] sel158(input logic [3:0] a, input logic [3:0] b,
                                         input logic sel, input logic str);
    if (str) return 4'b1111;
    return ~(sel ? a : b);
  endfunction

  function automatic void push(input string nm, input logic [3:0] e, input bit h);
    entry_t x;
    x.name = nm;
    x.exp  = e;
    x.hi   = h;
    sb.push_back(x);
  endfunction

  // Monitor: after each clock edge, or an asynchronous-event notification,
  // pop every pending expectation and compare against the DUT.
  initial begin
    entry_t     e;
    logic [3:0] act;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.hi ? hi_out : out;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  // One clocked operation: inputs change on the falling edge, expectation
  // is queued, and the next rising edge is where it must appear.
  task automatic step(input logic [1:0] m, input logic s_r, input logic s_l,
                      input logic [3:0] dd, input logic [3:0] exp, input string nm);
    @(negedge clk);
    mode <= m;
    sr   <= s_r;
    sl   <= s_l;
    d    <= dd;
    push(nm, exp, 1'b0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] sv [4];

    // Reset state: reset held across the first edge.
    @(negedge clk);
    push("reset_state", 4'b0000, 1'b0);
    @(posedge clk);
    #2;
    @(negedge clk);
    rst <= 1'b0;

    // 1. Asynchronous reset between edges while out = 1010.
    step(2'b11, 1'b0, 1'b0, 4'b1010, 4'b1010, "load_1010");
    @(negedge clk);
    #2;
    rst <= 1'b1;
    push("async_reset_immediate", 4'b0000, 1'b0);
    -> chk_ev;
    #2;
    step(2'b11, 1'b0, 1'b0, 4'b1111, 4'b0000, "reset_held_edge1");
    step(2'b01, 1'b1, 1'b0, 4'b1111, 4'b0000, "reset_held_edge2");
    @(negedge clk);
    rst <= 1'b0;

    // 2. Load from the selector, then hold while d changes.
    step(2'b11, 1'b0, 1'b0, sel158(4'b1010, 4'b1111, 1'b1, 1'b0), 4'b0101, "sel_load_0101");
    for (int i = 0; i < 3; i++)
      step(2'b00, 1'b1, 1'b1, sel158(4'b1010, 4'b1111, 1'b0, 1'b0), 4'b0101, "hold_0101");

    // 3. Shift right from 0000 with sr = 1, then a 0.
    step(2'b11, 1'b0, 1'b0, 4'b0000, 4'b0000, "load_0000");
    sv = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++)
      step(2'b01, 1'b1, 1'b0, 4'b1010, sv[i], "shift_right_ones");
    step(2'b01, 1'b0, 1'b1, 4'b1010, 4'b1110, "shift_right_zero");

    // 4. Shift left from 1001 with sl = 0, then sl = 1.
    step(2'b11, 1'b1, 1'b1, 4'b1001, 4'b1001, "load_1001");
    sv = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++)
      step(2'b10, 1'b1, 1'b0, 4'b1111, sv[i], "shift_left_zeros");
    step(2'b10, 1'b0, 1'b1, 4'b1111, 4'b1000, "shift_left_one");

    // 5. Reset in the middle of a shift-right of 0111, release on an edge.
    step(2'b11, 1'b0, 1'b0, 4'b0111, 4'b0111, "load_0111");
    @(negedge clk);
    mode <= 2'b01;
    sr   <= 1'b1;
    #2;
    rst <= 1'b1;
    push("mid_shift_reset", 4'b0000, 1'b0);
    -> chk_ev;
    #2;
    @(negedge clk);
    push("release_on_edge", 4'b0000, 1'b0);
    @(posedge clk);
    rst <= 1'b0;
    #2;
    step(2'b01, 1'b1, 1'b0, 4'b0000, 4'b0001, "first_edge_after_release");

    // 6. Two-stage shift-right cascade: MSB of low stage enters high stage.
    @(negedge clk);
    mode    <= 2'b11;
    d       <= 4'b1000;
    hi_mode <= 2'b11;
    hi_d    <= 4'b0000;
    push("cascade_load_lo", 4'b1000, 1'b0);
    push("cascade_load_hi", 4'b0000, 1'b1);
    @(posedge clk);
    #2;
    @(negedge clk);
    mode    <= 2'b01;
    sr      <= 1'b1;
    hi_mode <= 2'b01;
    push("cascade_lo", 4'b0001, 1'b0);
    push("cascade_hi", 4'b0001, 1'b1);
    @(posedge clk);
    #2;

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sn74xx194.md
# sn74xx194

Behavioural model of a 4-bit bidirectional universal shift register with parallel load, in the style of the 74194, for the TTL library. It sits directly downstream of the quad 2-to-1 data selector (SN74XX158): its parallel input `d` takes the selector's `out` bus, so a selected (inverted) nibble can be captured, held, or serialised on the next clock. The width is parameterised for chaining, and the default matches the selector's 4-bit bus.

## Interface
- `WIDTH`, default 4: register width in bits; legal values are ≥ 2.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous, active-high reset; clears the register.
- `mode`  input  2: operation select, {S1,S0}.
- `sr`  input  1: serial data for shift-right, entering at bit 0 (QA).
- `sl`  input  1: serial data for shift-left, entering at bit WIDTH-1 (QD).
- `d`  input  WIDTH: parallel load data; bit 0 corresponds to A.
- `out`  output  WIDTH: register contents; bit 0 is QA.

## Operation
- The register state `out` is the only storage. No combinational path runs from any input to `out`.
- While `rst` = 1: `out` = 0 immediately, independent of `clk`. Clock edges are ignored while reset is held.
- At each `clk` rising edge with `rst` = 0, the action depends on `mode`:
  - `00` hold: `out` is unchanged.
  - `01` shift right (toward MSB): `out` <= {out[WIDTH-2:0], sr}.
  - `10` shift left (toward LSB): `out` <= {sl, out[WIDTH-1:1]}.
  - `11` parallel load: `out` <= `d`.
- `mode` = x/z at an edge: `out` becomes all-x. This flags the fault in simulation. The model does not silently hold.
- Serial bits are sampled only in their own mode. In load and hold modes, `sr` and `sl` are don't-care.
- `d` is sampled only in mode `11`.
- Chaining:
  - Shift-right cascade: `out[WIDTH-1]` of stage n feeds `sr` of stage n+1.
  - Shift-left cascade: `out[0]` feeds `sl`.
  - No extra logic is required for either.

## Timing
- All state changes occur on the `clk` rising edge, except reset.
- Latency:
  - Load: `d` appears on `out` 1 clock after the edge.
  - Shift: one bit position per clock. A serial bit reaches the far end after WIDTH clocks.
- Setup: `mode`, `d`, `sr` and `sl` must be stable before the rising edge. In the bench, drive them with nonblocking assignments on the opposite phase.
- Reset assertion is asynchronous: `out` goes to 0 in the same time step as `rst` rises, including mid-shift.
- Reset deassertion:
  - The first edge that sees `rst` = 0 performs the selected operation.
  - If `rst` falls coincident with a `clk` edge, that edge is ignored; reset wins.
- Mode changes take effect on the next edge only. There is no partial or glitched state.
- Wrap-around: there is none. Bits shifted out of the end are lost, and the register is not circular unless the user externally ties `out[WIDTH-1]` to `sr`.

## Test plan
1. Reset: raise `rst` between edges while `out` = 1010.
   - Required: `out` = 0000 in the same time step.
   - Required: `out` stays 0000 across two clock edges while `rst` = 1.
2. Load from the selector: SN74XX158 with a=1010, b=1111, sel=1, str=0 drives `d` = 0101; apply `mode` = 11 for one edge.
   - Required: `out` = 0101.
   - Then, with sel=0 and `mode` = 00 for 3 edges, `out` must remain 0101 even though `d` changes to 0000.
3. Shift right: start from `out` = 0000 with `sr` = 1, `mode` = 01, 4 edges.
   - Required sequence: 0001, 0011, 0111, 1111.
   - Then set `sr` = 0 for one edge: `out` = 1110.
4. Shift left: load 1001, then `mode` = 10 with `sl` = 0 for 4 edges.
   - Required sequence: 0100, 0010, 0001, 0000.
   - A fifth edge with `sl` = 1 gives 1000.
5. Reset mid-operation and release: during shift-right of 0111, assert `rst` asynchronously.
   - Required: 0000 immediately.
   - Release `rst` coincident with an edge: `out` stays 0000.
   - Required: the next edge with `sr` = 1 gives 0001.
6. Cascade with WIDTH = 4, two instances, shift-right.
   - Stimulus: load 1000 into the low stage and 0000 into the high stage, then apply 1 edge.
   - Required: low stage = 000x-in (its `sr` value); high stage = 0001, so the MSB carries across the stages.
